// File: rtl/mlb_pkg.sv
// Shared definitions for the multi_layer_buffer load path.
// Holds the header field positions, the layer id width, the load FSM state
// encoding and the per-layer address stride helper.
package mlb_pkg;

  localparam int HDR_ID_LSB = 0;
  localparam int HDR_ID_MSB = 2;
  localparam int HDR_N_LSB  = 16;
  localparam int HDR_N_MSB  = 31;
  localparam int HDR_N_W    = HDR_N_MSB - HDR_N_LSB + 1;
  localparam int LAYER_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ld_state_t;

  // Words per layer region: the top three address bits select the layer.
  function automatic int unsigned stride(input int unsigned addr_w);
    return 32'd1 << (addr_w - 3);
  endfunction

endpackage

// File: rtl/layer_load_sequencer.sv
// layer_load_sequencer
// Turns a framed valid/ready word stream (header + N payload words per layer)
// into registered writes on multi_layer_buffer's host port, and tracks which
// layers hold a complete, error-free image.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last input word stream
//   host_wr_en/host_layer_id/host_addr/host_wdata  buffer write port (registered)
//   layer_valid, layer_valid_clr  per-layer loaded flags and clear requests
//   busy, load_done               packet in progress / end-of-packet pulse
//   load_err, err_clr             sticky error flag and its clear
module layer_load_sequencer
  import mlb_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  host_wr_en,
  output logic [LAYER_ID_W-1:0] host_layer_id,
  output logic [ADDR_WIDTH-1:0] host_addr,
  output logic [DATA_WIDTH-1:0] host_wdata,
  output logic [NUM_LAYERS-1:0] layer_valid,
  input  logic [NUM_LAYERS-1:0] layer_valid_clr,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err,
  input  logic                  err_clr
);

  localparam int unsigned STRIDE = stride(ADDR_WIDTH);

  ld_state_t             state, nstate;
  logic [LAYER_ID_W-1:0] id_q;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [HDR_N_W-1:0]    remaining;
  logic                  pkt_err;

  logic                  accept;
  logic                  err_set;
  logic                  enter_load;
  logic [LAYER_ID_W-1:0] hdr_id;
  logic [HDR_N_W-1:0]    hdr_n;

  function automatic logic hdr_legal(input logic [LAYER_ID_W-1:0] id,
                                     input logic [HDR_N_W-1:0] n);
    return (n != '0) && (32'(n) <= STRIDE) && (32'(id) < NUM_LAYERS);
  endfunction

  assign hdr_id    = s_data[HDR_ID_MSB:HDR_ID_LSB];
  assign hdr_n     = s_data[HDR_N_MSB:HDR_N_LSB];
  // Held low while rst is asserted so no beat is taken in the reset cycle.
  assign s_ready   = !rst && (state != DONE);
  assign accept    = s_valid && s_ready;
  assign busy      = (state != IDLE);
  assign load_done = (state == DONE);

  always_comb begin
    nstate     = state;
    err_set    = 1'b0;
    enter_load = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (s_last) begin
          err_set = 1'b1;
          nstate  = DONE;
        end else if (hdr_legal(hdr_id, hdr_n)) begin
          enter_load = 1'b1;
          nstate     = LOAD;
        end else begin
          err_set = 1'b1;
          nstate  = DRAIN;
        end
      end
      LOAD: if (accept) begin
        if (remaining == HDR_N_W'(1)) begin
          err_set = !s_last;
          nstate  = s_last ? DONE : DRAIN;
        end else if (s_last) begin
          err_set = 1'b1;
          nstate  = DONE;
        end
      end
      DRAIN: if (accept && s_last) nstate = DONE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // ---- control registers: FSM, counters, flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      id_q        <= '0;
      addr_cnt    <= '0;
      remaining   <= '0;
      pkt_err     <= 1'b0;
      load_err    <= 1'b0;
      layer_valid <= '0;
    end else begin
      state <= nstate;

      if (state == IDLE && accept) begin
        id_q      <= hdr_id;
        addr_cnt  <= '0;
        remaining <= hdr_n;
        pkt_err   <= err_set;
      end else begin
        if (state == LOAD && accept) begin
          addr_cnt  <= addr_cnt + 1'b1;
          remaining <= remaining - 1'b1;
        end
        if (err_set) pkt_err <= 1'b1;
      end

      if (err_set)      load_err <= 1'b1;
      else if (err_clr) load_err <= 1'b0;

      // Clear requests first, then a fresh load invalidates its layer, and a
      // clean DONE sets it last so a same-cycle clear loses.
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (enter_load && LAYER_ID_W'(i) == hdr_id)
          layer_valid[i] <= 1'b0;
        else if (state == DONE && !pkt_err && LAYER_ID_W'(i) == id_q)
          layer_valid[i] <= 1'b1;
        else if (layer_valid_clr[i])
          layer_valid[i] <= 1'b0;
      end
    end
  end

  // ---- write port stage: one cycle behind the accepted beat ----
  always_ff @(posedge clk) begin
    if (rst) begin
      host_wr_en    <= 1'b0;
      host_layer_id <= '0;
      host_addr     <= '0;
      host_wdata    <= '0;
    end else begin
      host_wr_en <= (state == LOAD) && accept;
      if ((state == LOAD) && accept) begin
        host_layer_id <= id_q;
        host_addr     <= addr_cnt;
        host_wdata    <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_layer_load_sequencer.sv
module tb_layer_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        host_wr_en;
  logic [2:0]  host_layer_id;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [7:0]  layer_valid;
  logic [7:0]  layer_valid_clr;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic        err_clr;

  layer_load_sequencer #(.NUM_LAYERS(8), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .host_wr_en(host_wr_en), .host_layer_id(host_layer_id),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .layer_valid(layer_valid), .layer_valid_clr(layer_valid_clr),
    .busy(busy), .load_done(load_done), .load_err(load_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t wq[$];
  int  done_cnt;
  int  checks = 0;
  int  errors = 0;

  always @(negedge clk) begin
    if (host_wr_en) wq.push_back('{host_layer_id, host_addr, host_wdata});
    if (load_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [2:0] id, input logic [15:0] n);
    return {n, 13'd0, id};
  endfunction

  task automatic send(input logic [31:0] d, input logic last, input int gap);
    int n;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", {63'd0, s_ready}, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic start_pkt();
    wq.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b1; s_valid = 0; s_data = 0; s_last = 0;
    layer_valid_clr = 0; err_clr = 0; done_cnt = 0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_wr_en", {63'd0, host_wr_en}, 64'd0);
    check("rst_addr", {48'd0, host_addr}, 64'd0);
    check("rst_wdata", {32'd0, host_wdata}, 64'd0);
    check("rst_valid", {56'd0, layer_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_err", {63'd0, load_err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {63'd0, s_ready}, 64'd1);

    // 1: clean load, layer 2, 4 words
    start_pkt();
    send(hdr(3'd2, 16'd4), 1'b0, 0);
    for (int i = 0; i < 4; i++) send(32'hA0 + i, i == 3, 0);
    settle();
    check("t1_nwr", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++)
      check($sformatf("t1_wr%0d", i), {13'd0, wq[i]}, {13'd0, 3'd2, 16'(i), 32'hA0 + i});
    check("t1_done", done_cnt, 1);
    check("t1_valid", {56'd0, layer_valid}, 64'h04);
    check("t1_err", {63'd0, load_err}, 64'd0);

    // 2: short packet, layer 5
    start_pkt();
    send(hdr(3'd5, 16'd3), 1'b0, 0);
    send(32'hB0, 1'b0, 0);
    send(32'hB1, 1'b1, 0);
    settle();
    check("t2_nwr", wq.size(), 2);
    check("t2_err", {63'd0, load_err}, 64'd1);
    check("t2_valid", {56'd0, layer_valid}, 64'h04);
    check("t2_done", done_cnt, 1);
    pulse_err_clr();
    check("t2_errclr", {63'd0, load_err}, 64'd0);

    // 3: long packet, layer 1, drained
    start_pkt();
    send(hdr(3'd1, 16'd2), 1'b0, 0);
    for (int i = 0; i < 4; i++) send(32'hC0 + i, i == 3, 0);
    settle();
    check("t3_nwr", wq.size(), 2);
    if (wq.size() == 2) check("t3_wr1", {13'd0, wq[1]}, {13'd0, 3'd1, 16'd1, 32'hC1});
    check("t3_err", {63'd0, load_err}, 64'd1);
    check("t3_valid", {56'd0, layer_valid}, 64'h04);
    pulse_err_clr();

    // 4: N=0 and N=STRIDE+1 rejected, then N=STRIDE accepted
    start_pkt();
    send(hdr(3'd0, 16'd0), 1'b0, 0);
    send(32'hD0, 1'b0, 0);
    send(32'hD1, 1'b1, 0);
    settle();
    check("t4_n0_nwr", wq.size(), 0);
    check("t4_n0_err", {63'd0, load_err}, 64'd1);
    check("t4_n0_done", done_cnt, 1);
    pulse_err_clr();
    start_pkt();
    send(hdr(3'd0, 16'd8193), 1'b0, 0);
    send(32'hD2, 1'b1, 0);
    settle();
    check("t4_big_nwr", wq.size(), 0);
    check("t4_big_err", {63'd0, load_err}, 64'd1);
    pulse_err_clr();
    start_pkt();
    send(hdr(3'd0, 16'd8192), 1'b0, 0);
    for (int i = 0; i < 8192; i++) send(32'h5000_0000 + i, i == 8191, 0);
    settle();
    check("t4_full_nwr", wq.size(), 8192);
    bad = 0;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i].addr != 16'(i) || wq[i].data != 32'h5000_0000 + i || wq[i].id != 3'd0) bad++;
    check("t4_full_order", bad, 0);
    if (wq.size() > 0) check("t4_last_addr", {48'd0, wq[wq.size()-1].addr}, 64'd8191);
    check("t4_valid", {56'd0, layer_valid}, 64'h05);
    check("t4_err", {63'd0, load_err}, 64'd0);

    // 5: gapped load layer 3, then reset mid-packet
    start_pkt();
    send(hdr(3'd3, 16'd16), 1'b0, $urandom_range(0, 1));
    for (int i = 0; i < 16; i++) send(32'hE0 + i, i == 15, $urandom_range(0, 1));
    settle();
    check("t5_nwr", wq.size(), 16);
    bad = 0;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i].addr != 16'(i) || wq[i].data != 32'hE0 + i || wq[i].id != 3'd3) bad++;
    check("t5_order", bad, 0);
    check("t5_valid", {56'd0, layer_valid}, 64'h0D);
    send(hdr(3'd4, 16'd8), 1'b0, 0);
    for (int i = 0; i < 3; i++) send(32'hF0 + i, 1'b0, 0);
    check("t5_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_wr", {63'd0, host_wr_en}, 64'd0);
    check("t5_rst_addr", {48'd0, host_addr}, 64'd0);
    check("t5_rst_wdata", {32'd0, host_wdata}, 64'd0);
    check("t5_rst_valid", {56'd0, layer_valid}, 64'd0);
    check("t5_rst_busy", {63'd0, busy}, 64'd0);
    check("t5_rst_ready", {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after", {63'd0, s_ready}, 64'd1);

    // 6: set wins over clear in DONE; reload invalidates; err_clr
    send(hdr(3'd3, 16'd2), 1'b0, 0);
    send(32'h11, 1'b0, 0);
    send(32'h12, 1'b1, 0);
    settle();
    check("t6_valid1", {56'd0, layer_valid}, 64'h08);
    send(hdr(3'd3, 16'd2), 1'b0, 0);
    check("t6_reload_clr", {56'd0, layer_valid}, 64'h00);
    send(32'h21, 1'b0, 0);
    send(32'h22, 1'b1, 0);
    check("t6_in_done", {63'd0, load_done}, 64'd1);
    layer_valid_clr = 8'h08;
    @(posedge clk);
    #1;
    layer_valid_clr = 8'h00;
    check("t6_set_wins", {56'd0, layer_valid}, 64'h08);
    @(negedge clk);
    layer_valid_clr = 8'h08;
    @(negedge clk);
    layer_valid_clr = 8'h00;
    check("t6_clr", {56'd0, layer_valid}, 64'h00);
    send(hdr(3'd6, 16'd3), 1'b0, 0);
    send(32'h31, 1'b1, 0);
    settle();
    check("t6_err_set", {63'd0, load_err}, 64'd1);
    pulse_err_clr();
    check("t6_err_clr", {63'd0, load_err}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
